// File: rtl/onehot_arb_mux.sv
// N-channel, W-bit one-hot selector with round-robin or fixed-priority
// arbitration, an external one-hot override and a registered
// valid/ready output stage.
module onehot_arb_mux #(
    parameter int unsigned W  = 32,
    parameter int unsigned N  = 6,
    parameter int unsigned RR = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           sel_en,
    input  logic [N-1:0]   sel_onehot,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_grant,
    output logic           sel_err,
    input  logic           err_clr
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);

    logic [PW-1:0] ptr;
    logic          load_c;
    logic          legal_c;
    logic          xfer_c;
    logic [CW-1:0] cnt_c;
    logic [N-1:0]  arb_c;
    logic [N-1:0]  grant_c;
    logic [W-1:0]  data_c;
    logic [PW-1:0] gidx_c;

    // The output register can take a new word when empty or being drained.
    assign load_c = !out_valid || out_ready;

    // Population count of the external select, for legality checking.
    always_comb begin
        cnt_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cnt_c = cnt_c + CW'(sel_onehot[k]);
        end
    end

    assign legal_c = (cnt_c == CW'(1));

    // Arbitration: first valid channel starting at ptr (RR) or at 0 (fixed).
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        arb_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (RR != 0) begin
                idx = PW'((32'(ptr) + i) % N);
            end else begin
                idx = PW'(i);
            end
            if (!found && in_valid[idx]) begin
                arb_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Final grant: override when sel_en, otherwise arbitration; none when stalled.
    always_comb begin
        grant_c = '0;
        if (load_c) begin
            if (sel_en) begin
                grant_c = legal_c ? (sel_onehot & in_valid) : '0;
            end else begin
                grant_c = arb_c;
            end
        end
    end

    assign in_ready = rst_n ? grant_c : '0;
    assign xfer_c   = |grant_c;

    // Pick the single granted channel's data and index (never OR-merged).
    always_comb begin
        data_c = '0;
        gidx_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant_c[k]) begin
                data_c = in_data[k*W +: W];
                gidx_c = PW'(k);
            end
        end
    end

    // Output register: capture on transfer, go idle on an empty load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
        end else if (load_c) begin
            out_valid <= xfer_c;
            if (xfer_c) begin
                out_data  <= data_c;
                out_grant <= grant_c;
            end
        end
    end

    // Round-robin pointer moves just past the channel that transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((RR != 0) && xfer_c) begin
            ptr <= (gidx_c == PW'(N - 1)) ? '0 : gidx_c + PW'(1);
        end
    end

    // Sticky illegal-select flag; a new violation beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (sel_en && !legal_c) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onehot_arb_mux.sv
// Scoreboard bench for onehot_arb_mux: a round-robin and a fixed-priority
// instance, directed stimulus, expected words queued and checked on output.
module tb_onehot_arb_mux;

    localparam int unsigned W = 32;
    localparam int unsigned N = 6;

    typedef struct {
        logic [W-1:0] d;
        logic [N-1:0] g;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           sel_en;
    logic [N-1:0]   sel_onehot;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_grant;
    logic           sel_err;
    logic           err_clr;

    logic [N-1:0]   fp_valid;
    logic [N-1:0]   fp_in_ready;
    logic [W-1:0]   fp_data;
    logic           fp_out_valid;
    logic           fp_ready;
    logic [N-1:0]   fp_grant;
    logic           fp_sel_err;

    exp_t rr_q[$];
    exp_t fp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    onehot_arb_mux #(.W(W), .N(N), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel_en(sel_en), .sel_onehot(sel_onehot),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_grant(out_grant), .sel_err(sel_err), .err_clr(err_clr)
    );

    onehot_arb_mux #(.W(W), .N(N), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(fp_valid),
        .in_ready(fp_in_ready), .sel_en(sel_en), .sel_onehot(sel_onehot),
        .out_data(fp_data), .out_valid(fp_out_valid), .out_ready(fp_ready),
        .out_grant(fp_grant), .sel_err(fp_sel_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'(k + 'h100);
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic [N-1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        return e;
    endfunction

    initial begin
        rst_n      = 1'b0;
        in_valid   = 6'h3F;
        sel_en     = 1'b0;
        sel_onehot = '0;
        err_clr    = 1'b0;
        out_ready  = 1'b1;
        fp_valid   = '0;
        fp_ready   = 1'b1;
        set_data();

        fork
            // Monitor: compare each consumed output word against the scoreboard.
            forever begin
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (rr_q.size() == 0) begin
                        chk("rr_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = rr_q.pop_front();
                        chk("rr_out_data", 32'(out_data), 32'(e.d));
                        chk("rr_out_grant", 32'(out_grant), 32'(e.g));
                    end
                end
                if (rst_n && fp_out_valid && fp_ready) begin
                    if (fp_q.size() == 0) begin
                        chk("fp_unexpected_word", 32'(fp_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = fp_q.pop_front();
                        chk("fp_out_data", 32'(fp_data), 32'(e.d));
                        chk("fp_out_grant", 32'(fp_grant), 32'(e.g));
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state, with all channels offering data.
        #3;
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", 32'(out_data), 32'h0);
        chk("reset_out_grant", 32'(out_grant), 32'h0);
        chk("reset_sel_err", 32'(sel_err), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Round-robin over all channels, back-to-back.
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(6'b1 << (i % 6)));
            rr_q.push_back(mk(32'(32'h100 + (i % 6)), 6'(6'b1 << (i % 6))));
            step();
            chk("rr_out_valid_cont", 32'(out_valid), 32'h1);
        end

        // Backpressure while 0x102 is held.
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", 32'(out_data), 32'h102);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_in_ready_hold", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'(6'b001000));
        rr_q.push_back(mk(32'h103, 6'b001000));
        step();

        // Move ptr to 1 via channel 0 so the override differs from arbitration.
        in_valid = 6'b000001;
        rr_q.push_back(mk(32'h100, 6'b000001));
        step();

        // Legal override of channel 4.
        in_valid             = 6'h3F;
        sel_en               = 1'b1;
        sel_onehot           = 6'b010000;
        in_data[4*W +: W]    = 32'hDEAD_BEEF;
        #1;
        chk("ovr_in_ready", 32'(in_ready), 32'(6'b010000));
        rr_q.push_back(mk(32'hDEAD_BEEF, 6'b010000));
        step();

        // Illegal (two-hot) override.
        sel_onehot = 6'b010001;
        #1;
        chk("ill_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("ill_sel_err", 32'(sel_err), 32'h1);
        chk("ill_out_valid", 32'(out_valid), 32'h0);
        chk("ill_out_data_held", 32'(out_data), 32'hDEAD_BEEF);

        // Clear together with an illegal select: set wins.
        err_clr = 1'b1;
        step();
        chk("clr_vs_set", 32'(sel_err), 32'h1);

        // Clear with a legal select.
        sel_onehot = 6'b010000;
        rr_q.push_back(mk(32'hDEAD_BEEF, 6'b010000));
        step();
        chk("clr_legal", 32'(sel_err), 32'h0);
        err_clr = 1'b0;

        // Override of a channel that is not valid grants nothing.
        in_valid = 6'b101111;
        #1;
        chk("ovr_invalid_ch", 32'(in_ready), 32'h0);
        step();
        chk("ovr_invalid_err", 32'(sel_err), 32'h0);

        // Wrap: ptr=5, only channel 5 valid, then all valid -> channel 0.
        set_data();
        sel_en     = 1'b0;
        sel_onehot = '0;
        in_valid   = 6'b100000;
        #1;
        chk("wrap_ch5", 32'(in_ready), 32'(6'b100000));
        rr_q.push_back(mk(32'h105, 6'b100000));
        step();
        in_valid = 6'h3F;
        #1;
        chk("wrap_ch0", 32'(in_ready), 32'(6'b000001));
        rr_q.push_back(mk(32'h100, 6'b000001));
        step();

        // Idle: valid drops, data and grant hold.
        in_valid = '0;
        step();
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_data_held", 32'(out_data), 32'h100);
        chk("idle_grant_held", 32'(out_grant), 32'(6'b000001));

        // Fixed priority on the second instance.
        fp_valid = 6'b101100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_in_ready_ch2", 32'(fp_in_ready), 32'(6'b000100));
            fp_q.push_back(mk(32'h102, 6'b000100));
            step();
        end
        fp_valid = 6'b101000;
        #1;
        chk("fp_in_ready_ch3", 32'(fp_in_ready), 32'(6'b001000));
        fp_q.push_back(mk(32'h103, 6'b001000));
        step();
        fp_valid = '0;
        step();

        // Mid-operation reset with a held word and sel_err set.
        in_valid = 6'b000100;
        rr_q.push_back(mk(32'h102, 6'b000100));
        step();
        in_valid   = '0;
        out_ready  = 1'b0;
        sel_en     = 1'b1;
        sel_onehot = '0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        chk("pre_rst_sel_err", 32'(sel_err), 32'h1);
        sel_en   = 1'b0;
        in_valid = 6'h3F;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        chk("mid_rst_grant", 32'(out_grant), 32'h0);
        chk("mid_rst_sel_err", 32'(sel_err), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        rr_q.delete();
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ch0", 32'(in_ready), 32'(6'b000001));
        rr_q.push_back(mk(32'h100, 6'b000001));
        step();
        in_valid = '0;

        // Drain the scoreboards with a bounded wait.
        for (int i = 0; i < 20 && (rr_q.size() != 0 || fp_q.size() != 0); i++) begin
            step();
        end
        chk("drain_rr_left", 32'(rr_q.size()), 32'h0);
        chk("drain_fp_left", 32'(fp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
